// File: rtl/mc_ctrl_if.sv
// Control bundle between the mc_ctrl sequencer (slave) and the MIPS datapath (master).
// MC_PERF_CNT_EN adds the cycle_cnt/retire_cnt performance counter outputs.
interface mc_ctrl_if;
  logic [5:0] Op;
  logic [5:0] Func;
  logic       mem_ready;
  logic [2:0] RegDstSel;
  logic [2:0] ALUSrcSel;
  logic [2:0] toRegSel;
  logic [2:0] NPCOp;
  logic [3:0] ALUOp;
  logic [2:0] EXTOp;
  logic [2:0] DMType;
  logic       RegWrite;
  logic       MemWrite;
  logic       PCWr;
  logic [2:0] state;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] retire_cnt;

  modport master (
    output Op, Func, mem_ready,
    input  RegDstSel, ALUSrcSel, toRegSel, NPCOp, ALUOp, EXTOp, DMType,
    input  RegWrite, MemWrite, PCWr, state, cycle_cnt, retire_cnt
  );
  modport slave (
    input  Op, Func, mem_ready,
    output RegDstSel, ALUSrcSel, toRegSel, NPCOp, ALUOp, EXTOp, DMType,
    output RegWrite, MemWrite, PCWr, state, cycle_cnt, retire_cnt
  );
`else
  modport master (
    output Op, Func, mem_ready,
    input  RegDstSel, ALUSrcSel, toRegSel, NPCOp, ALUOp, EXTOp, DMType,
    input  RegWrite, MemWrite, PCWr, state
  );
  modport slave (
    input  Op, Func, mem_ready,
    output RegDstSel, ALUSrcSel, toRegSel, NPCOp, ALUOp, EXTOp, DMType,
    output RegWrite, MemWrite, PCWr, state
  );
`endif
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB with PC write enable.
// Define MC_PERF_CNT_EN to add the cycle_cnt / retire_cnt performance counters.
module mc_ctrl (
  input  logic   clk,
  input  logic   reset,
  mc_ctrl_if.slave bus
);
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  logic [2:0] state_reg, state_next;

  logic r_type;
  logic is_add, is_sub, is_jr, is_ori, is_lui;
  logic is_lw, is_lb, is_sw, is_sb, is_beq, is_j, is_jal;
  logic is_load, is_store, is_alu_wb, is_defined;

  assign r_type   = (bus.Op == 6'h00);
  assign is_add   = r_type && (bus.Func == 6'h20);
  assign is_sub   = r_type && (bus.Func == 6'h22);
  assign is_jr    = r_type && (bus.Func == 6'h08);
  assign is_ori   = (bus.Op == 6'h0d);
  assign is_lui   = (bus.Op == 6'h0f);
  assign is_lw    = (bus.Op == 6'h23);
  assign is_lb    = (bus.Op == 6'h20);
  assign is_sw    = (bus.Op == 6'h2b);
  assign is_sb    = (bus.Op == 6'h28);
  assign is_beq   = (bus.Op == 6'h04);
  assign is_j     = (bus.Op == 6'h02);
  assign is_jal   = (bus.Op == 6'h03);

  assign is_load    = is_lw | is_lb;
  assign is_store   = is_sw | is_sb;
  assign is_alu_wb  = is_add | is_sub | is_ori | is_lui;
  assign is_defined = is_alu_wb | is_load | is_store | is_beq | is_j | is_jr | is_jal;

  // Selects are pure decode, gated off in FETCH and in the unused state codes.
  logic       sel_en;
  logic [2:0] regdst_next, alusrc_next, toreg_next, npcop_next, extop_next, dmtype_next;
  logic [3:0] aluop_next;

  assign sel_en = (state_reg != S_FETCH) && (state_reg <= S_WB);

  always_comb begin
    regdst_next = 3'd0;
    alusrc_next = 3'd0;
    toreg_next  = 3'd0;
    npcop_next  = 3'd0;
    aluop_next  = 4'd0;
    extop_next  = 3'd0;
    dmtype_next = 3'd0;
    if (sel_en) begin
      if (is_add || is_sub) begin
        regdst_next = 3'd1;
        aluop_next  = is_sub ? 4'd1 : 4'd0;
      end
      if (is_ori) begin
        alusrc_next = 3'd1;
        aluop_next  = 4'd2;
      end
      if (is_lui) begin
        extop_next = 3'd2;
        toreg_next = 3'd2;
      end
      if (is_load || is_store) begin
        extop_next  = 3'd1;
        alusrc_next = 3'd1;
        dmtype_next = (is_lb || is_sb) ? 3'd1 : 3'd0;
      end
      if (is_load)
        toreg_next = 3'd1;
      if (is_beq) begin
        aluop_next = 4'd1;
        npcop_next = 3'd1;
      end
      if (is_j)
        npcop_next = 3'd2;
      if (is_jal) begin
        npcop_next  = 3'd2;
        regdst_next = 3'd2;
        toreg_next  = 3'd3;
      end
      if (is_jr)
        npcop_next = 3'd3;
    end
  end

  // Next state and strobes; every instruction retires through exactly one PCWr cycle.
  logic regwrite_next, memwrite_next, pcwr_next;

  always_comb begin
    state_next    = S_FETCH;
    regwrite_next = 1'b0;
    memwrite_next = 1'b0;
    pcwr_next     = 1'b0;
    case (state_reg)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        if (is_defined)
          state_next = S_EXEC;
        else
          pcwr_next = 1'b1;
      end
      S_EXEC: begin
        if (is_alu_wb)
          state_next = S_WB;
        else if (is_load || is_store)
          state_next = S_MEM;
        else begin
          pcwr_next     = 1'b1;
          regwrite_next = is_jal;
        end
      end
      S_MEM: begin
        if (!bus.mem_ready)
          state_next = S_MEM;
        else if (is_store) begin
          memwrite_next = 1'b1;
          pcwr_next     = 1'b1;
        end else
          state_next = S_WB;
      end
      S_WB: begin
        regwrite_next = 1'b1;
        pcwr_next     = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_reg <= S_FETCH;
    else
      state_reg <= state_next;
  end

  assign bus.RegDstSel = regdst_next;
  assign bus.ALUSrcSel = alusrc_next;
  assign bus.toRegSel  = toreg_next;
  assign bus.NPCOp     = npcop_next;
  assign bus.ALUOp     = aluop_next;
  assign bus.EXTOp     = extop_next;
  assign bus.DMType    = dmtype_next;
  assign bus.RegWrite  = regwrite_next;
  assign bus.MemWrite  = memwrite_next;
  assign bus.PCWr      = pcwr_next;
  assign bus.state     = state_reg;

`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt_reg, retire_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt_reg  <= 32'd0;
      retire_cnt_reg <= 32'd0;
    end else begin
      cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
      if (pcwr_next)
        retire_cnt_reg <= retire_cnt_reg + 32'd1;
    end
  end

  assign bus.cycle_cnt  = cycle_cnt_reg;
  assign bus.retire_cnt = retire_cnt_reg;
`endif
endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle state, select and strobe checks per instruction class.
module tb_mc_ctrl;
  logic clk;
  logic reset;
  int   n_total = 0;
  int   n_pass  = 0;

  mc_ctrl_if bus ();

  mc_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [21:0] sel(input logic [2:0] rd, input logic [2:0] as,
                                      input logic [2:0] tr, input logic [2:0] npc,
                                      input logic [3:0] alu, input logic [2:0] ext,
                                      input logic [2:0] dm);
    return {rd, as, tr, npc, alu, ext, dm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Check the current cycle's outputs (inputs already applied), without advancing.
  task automatic look(input string tag, input logic [2:0] st, input logic [21:0] s,
                      input logic rw, input logic mw, input logic pw);
    logic [21:0] obs_sel;
    #1;
    obs_sel = {bus.RegDstSel, bus.ALUSrcSel, bus.toRegSel, bus.NPCOp,
               bus.ALUOp, bus.EXTOp, bus.DMType};
    chk({tag, "_state"}, {29'd0, bus.state}, {29'd0, st});
    chk({tag, "_sel"}, {10'd0, obs_sel}, {10'd0, s});
    chk({tag, "_strb"}, {29'd0, bus.RegWrite, bus.MemWrite, bus.PCWr}, {29'd0, rw, mw, pw});
    $display("step %s: state=%0d rw=%0b mw=%0b pcwr=%0b", tag, bus.state,
             bus.RegWrite, bus.MemWrite, bus.PCWr);
  endtask

  task automatic cyc(input string tag, input logic [2:0] st, input logic [21:0] s,
                     input logic rw, input logic mw, input logic pw);
    look(tag, st, s, rw, mw, pw);
    @(negedge clk);
  endtask

  logic [21:0] s_add, s_sub, s_ori, s_lui, s_lw, s_sb, s_beq, s_jal, s_jr;
`ifdef MC_PERF_CNT_EN
  logic [31:0] c0, r0;
`endif

  initial begin
    s_add = sel(3'd1, 3'd0, 3'd0, 3'd0, 4'd0, 3'd0, 3'd0);
    s_sub = sel(3'd1, 3'd0, 3'd0, 3'd0, 4'd1, 3'd0, 3'd0);
    s_ori = sel(3'd0, 3'd1, 3'd0, 3'd0, 4'd2, 3'd0, 3'd0);
    s_lui = sel(3'd0, 3'd0, 3'd2, 3'd0, 4'd0, 3'd2, 3'd0);
    s_lw  = sel(3'd0, 3'd1, 3'd1, 3'd0, 4'd0, 3'd1, 3'd0);
    s_sb  = sel(3'd0, 3'd1, 3'd0, 3'd0, 4'd0, 3'd1, 3'd1);
    s_beq = sel(3'd0, 3'd0, 3'd0, 3'd1, 4'd1, 3'd0, 3'd0);
    s_jal = sel(3'd2, 3'd0, 3'd3, 3'd2, 4'd0, 3'd0, 3'd0);
    s_jr  = sel(3'd0, 3'd0, 3'd0, 3'd3, 4'd0, 3'd0, 3'd0);

    reset = 1'b1;
    bus.Op = 6'h00;
    bus.Func = 6'h20;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    look("reset", 3'd0, 22'd0, 1'b0, 1'b0, 1'b0);
`ifdef MC_PERF_CNT_EN
    chk("reset_cycle_cnt", bus.cycle_cnt, 32'd0);
    chk("reset_retire_cnt", bus.retire_cnt, 32'd0);
`endif
    reset = 1'b0;

    // add: F D E WB; mem_ready high must be ignored outside MEM
    bus.mem_ready = 1'b1;
    cyc("add_F", 3'd0, 22'd0, 1'b0, 1'b0, 1'b0);
    cyc("add_D", 3'd1, s_add, 1'b0, 1'b0, 1'b0);
    cyc("add_E", 3'd2, s_add, 1'b0, 1'b0, 1'b0);
    cyc("add_WB", 3'd4, s_add, 1'b1, 1'b0, 1'b1);
    bus.mem_ready = 1'b0;

    // sub
    bus.Op = 6'h00; bus.Func = 6'h22;
    cyc("sub_F", 3'd0, 22'd0, 1'b0, 1'b0, 1'b0);
    cyc("sub_D", 3'd1, s_sub, 1'b0, 1'b0, 1'b0);
    cyc("sub_E", 3'd2, s_sub, 1'b0, 1'b0, 1'b0);
    cyc("sub_WB", 3'd4, s_sub, 1'b1, 1'b0, 1'b1);

    // ori
    bus.Op = 6'h0d; bus.Func = 6'h00;
    cyc("ori_F", 3'd0, 22'd0, 1'b0, 1'b0, 1'b0);
    cyc("ori_D", 3'd1, s_ori, 1'b0, 1'b0, 1'b0);
    cyc("ori_E", 3'd2, s_ori, 1'b0, 1'b0, 1'b0);
    cyc("ori_WB", 3'd4, s_ori, 1'b1, 1'b0, 1'b1);

    // lui
    bus.Op = 6'h0f;
    cyc("lui_F", 3'd0, 22'd0, 1'b0, 1'b0, 1'b0);
    cyc("lui_D", 3'd1, s_lui, 1'b0, 1'b0, 1'b0);
    cyc("lui_E", 3'd2, s_lui, 1'b0, 1'b0, 1'b0);
    cyc("lui_WB", 3'd4, s_lui, 1'b1, 1'b0, 1'b1);

    // lw aborted by reset in EXEC, between edges
    bus.Op = 6'h23;
    cyc("lwab_F", 3'd0, 22'd0, 1'b0, 1'b0, 1'b0);
    cyc("lwab_D", 3'd1, s_lw, 1'b0, 1'b0, 1'b0);
    look("lwab_E", 3'd2, s_lw, 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    look("lwab_rst", 3'd0, 22'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    look("lwab_hold", 3'd0, 22'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // lw with 3 stall cycles in MEM: 8 cycles total
    cyc("lw_F", 3'd0, 22'd0, 1'b0, 1'b0, 1'b0);
    cyc("lw_D", 3'd1, s_lw, 1'b0, 1'b0, 1'b0);
    cyc("lw_E", 3'd2, s_lw, 1'b0, 1'b0, 1'b0);
    cyc("lw_M0", 3'd3, s_lw, 1'b0, 1'b0, 1'b0);
    cyc("lw_M1", 3'd3, s_lw, 1'b0, 1'b0, 1'b0);
    cyc("lw_M2", 3'd3, s_lw, 1'b0, 1'b0, 1'b0);
    bus.mem_ready = 1'b1;
    cyc("lw_M3", 3'd3, s_lw, 1'b0, 1'b0, 1'b0);
    bus.mem_ready = 1'b0;
    cyc("lw_WB", 3'd4, s_lw, 1'b1, 1'b0, 1'b1);

    // sb with mem_ready high: MemWrite and PCWr together in MEM
    bus.Op = 6'h28; bus.mem_ready = 1'b1;
    cyc("sb_F", 3'd0, 22'd0, 1'b0, 1'b0, 1'b0);
    cyc("sb_D", 3'd1, s_sb, 1'b0, 1'b0, 1'b0);
    cyc("sb_E", 3'd2, s_sb, 1'b0, 1'b0, 1'b0);
    cyc("sb_M", 3'd3, s_sb, 1'b0, 1'b1, 1'b1);

    // beq then jal
    bus.Op = 6'h04;
    cyc("beq_F", 3'd0, 22'd0, 1'b0, 1'b0, 1'b0);
    cyc("beq_D", 3'd1, s_beq, 1'b0, 1'b0, 1'b0);
    cyc("beq_E", 3'd2, s_beq, 1'b0, 1'b0, 1'b1);
    bus.Op = 6'h03;
    cyc("jal_F", 3'd0, 22'd0, 1'b0, 1'b0, 1'b0);
    cyc("jal_D", 3'd1, s_jal, 1'b0, 1'b0, 1'b0);
    cyc("jal_E", 3'd2, s_jal, 1'b1, 1'b0, 1'b1);
    bus.mem_ready = 1'b0;

    // jr
    bus.Op = 6'h00; bus.Func = 6'h08;
    cyc("jr_F", 3'd0, 22'd0, 1'b0, 1'b0, 1'b0);
    cyc("jr_D", 3'd1, s_jr, 1'b0, 1'b0, 1'b0);
    cyc("jr_E", 3'd2, s_jr, 1'b0, 1'b0, 1'b1);

    // undefined op: F D, PCWr in DECODE with all selects 0
    bus.Op = 6'h3f; bus.Func = 6'h00;
`ifdef MC_PERF_CNT_EN
    #1;
    c0 = bus.cycle_cnt;
    r0 = bus.retire_cnt;
`endif
    cyc("undef_F", 3'd0, 22'd0, 1'b0, 1'b0, 1'b0);
    cyc("undef_D", 3'd1, 22'd0, 1'b0, 1'b0, 1'b1);
    look("undef_next", 3'd0, 22'd0, 1'b0, 1'b0, 1'b0);
`ifdef MC_PERF_CNT_EN
    chk("perf_cycle_delta", bus.cycle_cnt - c0, 32'd2);
    chk("perf_retire_delta", bus.retire_cnt - r0, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
